instr_mem_responder: RTL and testbench

- Responder end of the fetch-stage instruction-memory interface; the fetch pipe stage is the initiator.
- Accepts PC fetch requests on a valid/ready channel and reads a word-addressed instruction array with fixed latency.
- Returns each instruction, tagged with its PC, on a valid/ready response channel backed by a credit-protected response FIFO.
- Includes a write (load) port so the bench or boot logic can fill the array.

---
 rtl/instr_mem_responder.sv | 156 +++++++++++++++
 tb/tb_instr_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Fetch-side instruction memory responder: PC request in, {instruction, pc, fault} out after LATENCY cycles via a show-ahead FIFO.
// req_ready is credit-gated so responses are never dropped; optional flush port with IMEM_RSP_FLUSH_EN.
module instr_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instruction,
  output logic [ADDR_W-1:0]        rsp_pc,
  output logic                     rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
`ifdef IMEM_RSP_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + LATENCY + 1);
  localparam logic [CNT_W-1:0]  RSP_DEPTH_C = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W:0]    FULL_C      = (PTR_W + 1)'(RSP_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_C     = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LATENCY-1:0] stg_vld;
  logic [LATENCY-1:0] stg_flt;
  logic [ADDR_W-1:0]  stg_pc  [LATENCY];
  logic [DATA_W-1:0]  stg_dat [LATENCY];

  logic [DATA_W-1:0]  f_dat [RSP_DEPTH];
  logic [ADDR_W-1:0]  f_pc  [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] f_flt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     f_cnt;

  logic             clr;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] used;
  logic             accept;
  logic             req_fault;
  logic [IDX_W-1:0] req_idx;
  logic             push;
  logic             pop;
  logic             full;

`ifdef IMEM_RSP_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Credits come only from registered state, so a pop frees a slot one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CNT_W'(stg_vld[i]);
    end
    used = CNT_W'(f_cnt) + inflight;
  end

  assign req_ready = !rst && !clr && (used < RSP_DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign req_fault = (req_pc[1:0] != 2'b00) || ({2'b00, req_pc[ADDR_W-1:2]} >= DEPTH_C);
  assign req_idx   = req_pc[2 +: IDX_W];

  assign push      = stg_vld[LATENCY-1];
  assign rsp_valid = (f_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign full      = (f_cnt == FULL_C);

  // Array has no reset; a same-edge write leaves the read returning the old word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      stg_flt <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_pc[i]  <= '0;
        stg_dat[i] <= '0;
      end
    end else begin
      stg_vld[0] <= accept;
      stg_flt[0] <= req_fault;
      stg_pc[0]  <= req_pc;
      stg_dat[0] <= req_fault ? '0 : mem[req_idx];
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_flt[i] <= stg_flt[i-1];
        stg_pc[i]  <= stg_pc[i-1];
        stg_dat[i] <= stg_dat[i-1];
      end
      if (clr) begin
        stg_vld <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   f_cnt <= f_cnt + (PTR_W + 1)'(1);
        2'b01:   f_cnt <= f_cnt - (PTR_W + 1)'(1);
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_dat[wr_ptr] <= stg_dat[LATENCY-1];
      f_pc[wr_ptr]  <= stg_pc[LATENCY-1];
      f_flt[wr_ptr] <= stg_flt[LATENCY-1];
    end
  end

  // Outputs read as zero when empty so reset leaves them at 0 without clearing storage.
  assign rsp_instruction = rsp_valid ? f_dat[rd_ptr] : '0;
  assign rsp_pc          = rsp_valid ? f_pc[rd_ptr]  : '0;
  assign rsp_fault       = rsp_valid && f_flt[rd_ptr];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: reference memory model, randomized traffic, directed corner cases.
module tb_instr_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instruction;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        flush = 1'b0;

  instr_mem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instruction(rsp_instruction),
    .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IMEM_RSP_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flt;
    logic [31:0] dat;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model entry is built from the array as it stands before this edge's load.
  task automatic drive(input bit v, input logic [31:0] pc, input bit rr, input bit ld,
                       input logic [9:0] la, input logic [31:0] ld_d, input bit exact, output bit acc);
    exp_t e;
    @(negedge clk);
    req_valid = v; req_pc = pc; rsp_ready = rr;
    ld_en = ld; ld_addr = la; ld_data = ld_d;
    flush = 1'b0;
    #1;
    acc = v && req_ready;
    if (acc) begin
      e.pc    = pc;
      e.flt   = (pc % 4 != 0) || (pc / 4 >= DEPTH);
      e.dat   = e.flt ? 32'h0 : ref_mem[pc / 4];
      e.acc   = cyc + 1;
      e.exact = exact;
      sbq.push_back(e);
    end
    if (ld) ref_mem[la] = ld_d;
  endtask

  task automatic idle(input bit rr);
    bit a;
    drive(1'b0, 32'h0, rr, 1'b0, 10'h0, 32'h0, 1'b0, a);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      idle(1'b1);
      k++;
    end
    chk("drain_empty", sbq.size(), 0);
    idle(1'b1);
    idle(1'b1);
  endtask

  // Monitor: every presented response is checked against the queue head; popped on handshake.
  always begin
    exp_t h;
    @(negedge clk);
    #2;
    if (!rst && !flush && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 1'b0);
      end else begin
        h = sbq[0];
        chk("rsp_pc", rsp_pc, h.pc);
        chk("rsp_fault", rsp_fault, h.flt);
        chk("rsp_instruction", rsp_instruction, h.dat);
        if (rsp_ready) begin
          if (h.exact) chk("latency", cyc, h.acc + LAT);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit a;
    int n;
    int r;
    logic [31:0] pc;

    // Reset state
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_instruction", rsp_instruction, 0);
    chk("rst_rsp_pc", rsp_pc, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    // Fill words 0..63; 0..3 hold A0..A3
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 10'(i), (i < 4) ? 32'hA0 + 32'(i) : $urandom, 1'b0, a);
    end
    idle(1'b1);

    // Back-to-back stream with exact latency
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 10'h0, 32'h0, 1'b1, a);
    drain();

    // Backpressure: credits cap acceptance at RSP_DEPTH
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, a);
      if (a) n++;
    end
    chk("credit_accepts", n, 4);
    chk("credit_stall_ready", req_ready, 0);
    idle(1'b1);
    chk("ready_before_pop", req_ready, 0);
    idle(1'b1);
    chk("ready_after_pop", req_ready, 1);
    drain();

    // Faults interleaved with good requests
    drive(1'b1, 32'd0,    1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drive(1'b1, 32'd2,    1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drive(1'b1, 32'd4,    1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drive(1'b1, 32'd4096, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drive(1'b1, 32'd8,    1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drain();

    // Load and read of the same word in one cycle returns the old word
    drive(1'b1, 32'd20, 1'b1, 1'b1, 10'd5, 32'hDEAD, 1'b0, a);
    drive(1'b1, 32'd20, 1'b1, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drain();

    // Asynchronous reset with responses queued and in flight
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, a);
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_req_ready", req_ready, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);
    for (int i = 0; i < 10; i++) idle(1'b1);

`ifdef IMEM_RSP_FLUSH_EN
    // Flush with two queued entries
    drive(1'b1, 32'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, a);
    drive(1'b1, 32'd4, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, a);
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'd8; rsp_ready = 1'b0; ld_en = 1'b0;
    #1;
    chk("flush_req_ready", req_ready, 0);
    sbq.delete();
    idle(1'b1);
    chk("flush_rsp_valid", rsp_valid, 0);
    chk("flush_credits", req_ready, 1);
    drive(1'b1, 32'd16, 1'b1, 1'b0, 10'h0, 32'h0, 1'b1, a);
    drain();
`endif

    // Randomized traffic with concurrent loads and random backpressure
    for (int i = 0; i < 2000; i++) begin
      r = $urandom % 10;
      if (r == 0)      pc = 32'($urandom % 64) * 4 + 32'($urandom_range(1, 3));
      else if (r == 1) pc = (32'd1024 + 32'($urandom % 5000)) * 4;
      else             pc = 32'($urandom % 64) * 4;
      drive(($urandom % 4) != 0, pc, ($urandom % 4) != 0, ($urandom % 8) == 0,
            10'($urandom % 64), $urandom, 1'b0, a);
    end
    drain();
    chk("final_rsp_valid", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
